mem_arbiter: RTL
================

# mem_arbiter

Shares the CPU's single-port 16-bit block RAM between three requesters: instruction fetch (IF, from the controller's fetch state), load/store (LS, from the execute state), and display scan-out (DSP, read-only). Sits between the CPU controller/datapath and the memory. Grants at most one access per cycle, drives the RAM address/write port from registered state, and returns read data with a fixed latency. LS has priority; a starvation guard keeps DSP from being locked out.

## Interface
- `ADDR_W`, 16: address width
- `DATA_W`, 16: data width
- `STARVE_LIMIT`, 8: cycles DSP may wait before being promoted (1..15)

- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `IfReq` / `LsReq` / `DspReq`  in  1 each  access request, held until granted
- `IfAddr` / `LsAddr` / `DspAddr`  in  ADDR_W each  request address, stable while Req high
- `LsWE`  in  1  LS request is a write
- `LsWData`  in  DATA_W  LS write data
- `IfGnt` / `LsGnt` / `DspGnt`  out  1 each  one-cycle grant pulse
- `IfRValid` / `LsRValid` / `DspRValid`  out  1 each  read data valid
- `RData`  out  DATA_W  read data, shared by all requesters (= `MemRData`)
- `MemAddr`  out  ADDR_W  RAM address
- `MemWE`  out  1  RAM write enable
- `MemWData`  out  DATA_W  RAM write data
- `MemRData`  in  DATA_W  RAM read data, valid 1 cycle after address

## Operation
- FSM states: `IDLE` (no grant this cycle) and `GRANT` (one requester granted this cycle). `IDLE`→`GRANT` when any eligible Req is high; `GRANT`→`GRANT` when another eligible Req is high; `GRANT`→`IDLE` otherwise.
- Eligible: Req high and not the requester granted in the current cycle. Because of this mask, one requester can get at most one grant every other cycle. The cycle after its Gnt, a requester either drops Req or presents a new request.
- Priority among eligible requesters: LS > IF > DSP. A promoted DSP (see Configuration) goes above LS.
- On a grant edge, the following register together: the Gnt bit, `MemAddr` = granted address, `MemWE` = `LsWE` (LS grant only, else 0), and `MemWData` = `LsWData`.
- A read grant in cycle N sets the matching RValid in cycle N+1, with `RData` = `MemRData`. A write grant produces no RValid.
- Reset values: all Gnt = 0, all RValid = 0, `MemWE` = 0, `MemAddr` = 0, `MemWData` = 0, state `IDLE`, starvation count 0.
- Reset asserted mid-access: on that edge all outputs take their reset values. A read granted in the cycle before reset gets no RValid. A write is not issued if reset and grant coincide.

## Timing
- Request-to-grant latency: 1 cycle minimum (Req sampled at edge E, Gnt high after E).
- Grant-to-data latency: 1 cycle. Total read latency is 2 cycles when uncontended.
- Throughput: one access per cycle when at least two requesters alternate. A single requester alone gets one access every 2 cycles.
- Outputs are registered; there is no combinational path from Req to Gnt or Mem*.
- Simultaneous LS and IF requests: LS is granted at E+1, IF at E+2 (the LS mask makes IF the winner).

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments each cycle that `DspReq` is high and DSP is not granted.
  - It saturates at `STARVE_LIMIT`.
  - At the limit, DSP is promoted to top priority.
  - The counter clears on a DSP grant or when `DspReq` is low.
- Not defined: strict LS > IF > DSP priority, no counter logic. DSP can starve indefinitely.

## Structure
- Shared package `cpu_pkg` holds:
  - requester ID constants `REQ_IF`, `REQ_LS`, `REQ_DSP`;
  - FSM state encoding `ARB_IDLE`, `ARB_GRANT`;
  - default widths.
- One sub-module, `arb_starve_counter`: the saturating counter plus promote flag. It is instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- Reset held 3 cycles with all Req high → all Gnt/RValid/`MemWE` stay 0. First Gnt is `LsGnt` one cycle after Reset drops.
- `IfReq` alone, `IfAddr` = 0x0010, RAM[0x10] = 0xBEEF → `IfGnt` at E+1 with `MemAddr` = 0x0010, then `IfRValid` at E+2 with `RData` = 0xBEEF.
- `LsReq` write, `LsAddr` = 0x0040, `LsWData` = 0x1234, together with `IfReq` → `LsGnt` with `MemWE` = 1 at E+1, `IfGnt` at E+2, no `LsRValid`. A later read of 0x0040 returns 0x1234.
- LS and IF requesting back-to-back continuously → grants alternate LS, IF, LS, IF… with one grant per cycle.
- Guard enabled, `STARVE_LIMIT` = 8, LS/IF saturating the port and `DspReq` high → `DspGnt` asserts within 9 cycles. Guard disabled, same stimulus → no `DspGnt` over 100 cycles.
- Reset asserted in the cycle after an IF read grant → no `IfRValid`; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the CPU memory-arbiter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: default widths, requester bit positions in the one-hot request and
// grant vectors, arbiter FSM state encoding and the starvation counter width.
package cpu_pkg;

  // Default widths.
  localparam int CPU_ADDR_W       = 16;
  localparam int CPU_DATA_W       = 16;
  localparam int ARB_STARVE_LIMIT = 8;
  localparam int ARB_STARVE_CNT_W = 4;

  // Requester IDs, used as bit positions in the request/grant vectors.
  localparam int ARB_NUM_REQ = 3;
  localparam int REQ_IF      = 0;
  localparam int REQ_LS      = 1;
  localparam int REQ_DSP     = 2;

  // Arbiter FSM encoding.
  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating wait counter for the display requester; flags promotion at the limit.
// Latency: promote_o is registered state, asserted the cycle after the count reaches LIMIT.
// Backpressure: none; it observes request/grant only.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   dsp_req_i  display request
//   dsp_gnt_i  display grant, high in the cycle the display owns the port
//   promote_o  high while the count sits at LIMIT
module arb_starve_counter
  import cpu_pkg::*;
#(
  parameter int LIMIT = ARB_STARVE_LIMIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dsp_req_i,
  input  logic dsp_gnt_i,
  output logic promote_o
);

  localparam logic [ARB_STARVE_CNT_W-1:0] LIM = ARB_STARVE_CNT_W'(LIMIT);
  localparam logic [ARB_STARVE_CNT_W-1:0] ONE = ARB_STARVE_CNT_W'(1);

  logic [ARB_STARVE_CNT_W-1:0] count_q, count_d;

  // Count only cycles where the display is waiting; a grant or a dropped
  // request restarts the measurement from zero.
  always_comb begin
    count_d = count_q;
    if (!dsp_req_i || dsp_gnt_i) begin
      count_d = '0;
    end else if (count_q != LIM) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign promote_o = (count_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between IF, LS and display requesters, LS > IF > DSP.
// Latency: Req to Gnt/Mem* 1 cycle (registered); Gnt to RValid 1 cycle; uncontended read 2 cycles.
// Backpressure: Req is held until the one-cycle Gnt pulse; a requester is masked the cycle after its grant.
// Optional feature: define ARB_STARVE_GUARD_EN to promote a display request that has
// waited STARVE_LIMIT cycles above LS. Without it priority is strictly LS > IF > DSP.
// Ports:
//   Clock, Reset                    clock, synchronous active-high reset
//   IfReq/LsReq/DspReq              requests, held until granted
//   IfAddr/LsAddr/DspAddr           request addresses
//   LsWE, LsWData                   LS write flag and write data
//   IfGnt/LsGnt/DspGnt              one-cycle grant pulses
//   IfRValid/LsRValid/DspRValid     read data valid, one cycle after a read grant
//   RData                           read data (straight from MemRData)
//   MemAddr, MemWE, MemWData        registered RAM port
//   MemRData                        RAM read data, valid one cycle after the address
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int DATA_W       = CPU_DATA_W,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic              LsReq,
  input  logic              DspReq,
  input  logic [ADDR_W-1:0] IfAddr,
  input  logic [ADDR_W-1:0] LsAddr,
  input  logic [ADDR_W-1:0] DspAddr,
  input  logic              LsWE,
  input  logic [DATA_W-1:0] LsWData,
  output logic              IfGnt,
  output logic              LsGnt,
  output logic              DspGnt,
  output logic              IfRValid,
  output logic              LsRValid,
  output logic              DspRValid,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [0:0]             state_q, state_d;
  logic [ARB_NUM_REQ-1:0] gnt_q;
  logic [ARB_NUM_REQ-1:0] rvld_q;
  logic [ADDR_W-1:0]      mem_addr_q, addr_d;
  logic                   mem_we_q, we_d;
  logic [DATA_W-1:0]      mem_wdata_q, wdata_d;

  logic [ARB_NUM_REQ-1:0] req, mask, elig, win;
  logic                   promote;

  assign req[REQ_IF]  = IfReq;
  assign req[REQ_LS]  = LsReq;
  assign req[REQ_DSP] = DspReq;

  // The requester that owns the port this cycle sits out the next decision,
  // which is what lets LS and IF interleave one access per cycle.
  assign mask = (state_q == ARB_GRANT) ? gnt_q : '0;
  assign elig = req & ~mask;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .dsp_req_i (DspReq),
    .dsp_gnt_i (gnt_q[REQ_DSP]),
    .promote_o (promote)
  );
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    win = '0;
    if (promote && elig[REQ_DSP]) begin
      win[REQ_DSP] = 1'b1;
    end else if (elig[REQ_LS]) begin
      win[REQ_LS] = 1'b1;
    end else if (elig[REQ_IF]) begin
      win[REQ_IF] = 1'b1;
    end else if (elig[REQ_DSP]) begin
      win[REQ_DSP] = 1'b1;
    end
  end

  assign state_d = (|elig) ? ARB_GRANT : ARB_IDLE;

  // RAM port next state; the address and write data hold when nothing is granted.
  always_comb begin
    addr_d  = mem_addr_q;
    we_d    = 1'b0;
    wdata_d = mem_wdata_q;
    if (|win) begin
      wdata_d = LsWData;
    end
    if (win[REQ_LS]) begin
      addr_d = LsAddr;
      we_d   = LsWE;
    end else if (win[REQ_IF]) begin
      addr_d = IfAddr;
    end else if (win[REQ_DSP]) begin
      addr_d = DspAddr;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rvld_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= win;
      // Data returns for the grant of the previous cycle; an LS write has no return.
      rvld_q[REQ_IF]  <= gnt_q[REQ_IF];
      rvld_q[REQ_LS]  <= gnt_q[REQ_LS] & ~mem_we_q;
      rvld_q[REQ_DSP] <= gnt_q[REQ_DSP];
      mem_addr_q  <= addr_d;
      mem_we_q    <= we_d;
      mem_wdata_q <= wdata_d;
    end
  end

  assign IfGnt     = gnt_q[REQ_IF];
  assign LsGnt     = gnt_q[REQ_LS];
  assign DspGnt    = gnt_q[REQ_DSP];
  assign IfRValid  = rvld_q[REQ_IF];
  assign LsRValid  = rvld_q[REQ_LS];
  assign DspRValid = rvld_q[REQ_DSP];
  assign RData     = MemRData;
  assign MemAddr   = mem_addr_q;
  assign MemWE     = mem_we_q;
  assign MemWData  = mem_wdata_q;

endmodule
